// File: rtl/ucie_ctl_rx_pkg.sv
// Shared definitions for the UCIe RX link sequencer.
// Holds the link-state encoding, the adapter request codes and the decode
// from state to the level-type datapath controls.
package ucie_ctl_rx_pkg;

  // The numeric values double as the status code seen on o_state_status.
  typedef enum logic [2:0] {
    ST_RESET     = 3'b000,
    ST_ACTIVE    = 3'b001,
    ST_DRAIN     = 3'b010,
    ST_RETRAIN   = 3'b011,
    ST_LINKERROR = 3'b100
  } rx_state_e;

  // Code 2'b11 is reserved and falls through every decode as a no-op.
  localparam logic [1:0] REQ_RESET   = 2'b00;
  localparam logic [1:0] REQ_ACTIVE  = 2'b01;
  localparam logic [1:0] REQ_RETRAIN = 2'b10;

  typedef struct packed {
    logic rx_enable;
    logic drain_enable;
    logic link_error;
  } rx_ctl_t;

  function automatic rx_ctl_t decode_state(input rx_state_e st);
    rx_ctl_t ctl;
    ctl = '0;
    case (st)
      ST_ACTIVE: begin
        ctl.rx_enable    = 1'b1;
        ctl.drain_enable = 1'b1;
      end
      ST_DRAIN:     ctl.drain_enable = 1'b1;
      ST_LINKERROR: ctl.link_error   = 1'b1;
      default:      ctl = '0;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/ucie_ctl_rx_drain_timer.sv
// Saturating cycle counter that bounds the time spent draining the RX buffer.
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_clear   forces the count back to zero (held while not draining)
//   i_enable  advances the count by one per cycle until it saturates
//   o_expire  high while the count sits at DRAIN_TIMEOUT-1
module ucie_ctl_rx_drain_timer #(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DRAIN_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Holding at LAST keeps o_expire asserted rather than wrapping to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (cnt_q == LAST);

endmodule

// File: rtl/ucie_ctl_rx_link_sequencer.sv
// UCIe RX link sequencer: walks the RX datapath through RESET, ACTIVE, DRAIN,
// RETRAIN and LINKERROR, gating RDI writes and FDI drain, flushing the buffer
// on teardown and escalating overflow or drain stalls to a sticky error.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET     | link down, writes and drain off, waits for an ACTIVE request
// ACTIVE    | normal traffic, writes and drain on
// DRAIN     | writes off, drain on until empty, then go to latched target
// RETRAIN   | link retraining, datapath idle
// LINKERROR | fatal error, datapath idle, left only by a RESET request
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_state_request       adapter request (00 RESET, 01 ACTIVE, 10 RETRAIN)
//   i_overflow_detected   overflow flag from the RX buffer
//   i_buf_count           RX buffer occupancy
//   o_rx_enable           allows RDI writes into the buffer
//   o_fdi_drain_enable    allows buffer reads toward FDI
//   o_buf_flush           one-cycle buffer clear
//   o_state_status        current state code
//   o_link_error          sticky error flag
//   o_drain_timeout       one-cycle pulse when a drain stalls out
import ucie_ctl_rx_pkg::*;

module ucie_ctl_rx_link_sequencer #(
  parameter int BUF_DEPTH     = 32,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [1:0]                     i_state_request,
  input  logic                           i_overflow_detected,
  input  logic [$clog2(BUF_DEPTH+1)-1:0] i_buf_count,
  output logic                           o_rx_enable,
  output logic                           o_fdi_drain_enable,
  output logic                           o_buf_flush,
  output logic [2:0]                     o_state_status,
  output logic                           o_link_error,
  output logic                           o_drain_timeout
);

  rx_state_e state_q, state_d;
  rx_state_e target_q, target_d;
  logic      flush_q, flush_d;
  logic      timeout_q, timeout_d;
  logic      drain_expire;
  logic      buf_empty;
  rx_ctl_t   ctl;

  assign buf_empty = (i_buf_count == '0);

  // Timer is held clear outside DRAIN, so it reads zero in the first DRAIN cycle.
  ucie_ctl_rx_drain_timer #(
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) u_drain_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (state_q != ST_DRAIN),
    .i_enable (state_q == ST_DRAIN),
    .o_expire (drain_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_RESET;
      target_q  <= ST_RESET;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_RESET: begin
        if (i_state_request == REQ_ACTIVE) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (i_overflow_detected) begin
          state_d = ST_LINKERROR;
        end else if (i_state_request == REQ_RETRAIN) begin
          state_d  = ST_DRAIN;
          target_d = ST_RETRAIN;
        end else if (i_state_request == REQ_RESET) begin
          state_d  = ST_DRAIN;
          target_d = ST_RESET;
        end
      end
      ST_DRAIN: begin
        // Requests are ignored here; the target latched on entry decides the exit.
        if (i_overflow_detected) begin
          state_d = ST_LINKERROR;
        end else if (buf_empty) begin
          state_d = target_q;
        end else if (drain_expire) begin
          state_d   = ST_LINKERROR;
          timeout_d = 1'b1;
        end
      end
      ST_RETRAIN: begin
        if (i_state_request == REQ_ACTIVE) begin
          state_d = ST_ACTIVE;
        end else if (i_state_request == REQ_RESET) begin
          state_d = ST_RESET;
        end
      end
      ST_LINKERROR: begin
        if (i_state_request == REQ_RESET) state_d = ST_RESET;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_comb begin
    // Flush fires on any transition into RESET or LINKERROR; leaving i_rst is not a transition.
    flush_d = (state_d != state_q) &&
              ((state_d == ST_RESET) || (state_d == ST_LINKERROR));
    ctl                = decode_state(state_q);
    o_rx_enable        = ctl.rx_enable;
    o_fdi_drain_enable = ctl.drain_enable;
    o_link_error       = ctl.link_error;
    o_state_status     = state_q;
    o_buf_flush        = flush_q;
    o_drain_timeout    = timeout_q;
  end

endmodule

// File: tb/tb_ucie_ctl_rx_link_sequencer.sv
// Self-checking bench for ucie_ctl_rx_link_sequencer: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_ucie_ctl_rx_link_sequencer;

  localparam int BUF_DEPTH     = 32;
  localparam int DRAIN_TIMEOUT = 64;
  localparam int CW            = $clog2(BUF_DEPTH + 1);

  // Model link modes, numbered with the published status codes.
  localparam int M_RESET = 0, M_ACTIVE = 1, M_DRAIN = 2, M_RETRAIN = 3, M_ERR = 4;

  logic          clk;
  logic          i_rst;
  logic [1:0]    i_state_request;
  logic          i_overflow_detected;
  logic [CW-1:0] i_buf_count;
  logic          o_rx_enable, o_fdi_drain_enable, o_buf_flush;
  logic [2:0]    o_state_status;
  logic          o_link_error, o_drain_timeout;
  logic [7:0]    dut_vec;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_mode   = M_RESET;
  int m_target = M_RESET;
  int m_waited = 0;      // completed cycles already spent draining
  bit m_flush  = 0;
  bit m_tout   = 0;

  ucie_ctl_rx_link_sequencer #(
    .BUF_DEPTH     (BUF_DEPTH),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .i_clk               (clk),
    .i_rst               (i_rst),
    .i_state_request     (i_state_request),
    .i_overflow_detected (i_overflow_detected),
    .i_buf_count         (i_buf_count),
    .o_rx_enable         (o_rx_enable),
    .o_fdi_drain_enable  (o_fdi_drain_enable),
    .o_buf_flush         (o_buf_flush),
    .o_state_status      (o_state_status),
    .o_link_error        (o_link_error),
    .o_drain_timeout     (o_drain_timeout)
  );

  // {status[2:0], rx_enable, drain_enable, flush, link_error, drain_timeout}
  assign dut_vec = {o_state_status, o_rx_enable, o_fdi_drain_enable,
                    o_buf_flush, o_link_error, o_drain_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit rst, input logic [1:0] req, input bit ovf, input int cnt);
    int nxt;
    if (rst) begin
      m_mode = M_RESET; m_target = M_RESET; m_waited = 0; m_flush = 0; m_tout = 0;
      return;
    end
    nxt    = m_mode;
    m_tout = 0;
    if (m_mode == M_RESET && req == 2'd1) nxt = M_ACTIVE;
    else if (m_mode == M_ACTIVE) begin
      if (ovf) nxt = M_ERR;
      else if (req == 2'd2) begin nxt = M_DRAIN; m_target = M_RETRAIN; end
      else if (req == 2'd0) begin nxt = M_DRAIN; m_target = M_RESET; end
    end else if (m_mode == M_DRAIN) begin
      if (ovf) nxt = M_ERR;
      else if (cnt == 0) nxt = m_target;
      else if (m_waited + 1 >= DRAIN_TIMEOUT) begin nxt = M_ERR; m_tout = 1; end
    end else if (m_mode == M_RETRAIN) begin
      if (req == 2'd1) nxt = M_ACTIVE;
      else if (req == 2'd0) nxt = M_RESET;
    end else if (m_mode == M_ERR && req == 2'd0) nxt = M_RESET;
    m_flush  = (nxt != m_mode) && (nxt == M_RESET || nxt == M_ERR);
    m_waited = (nxt == M_DRAIN && m_mode == M_DRAIN) ? m_waited + 1 : 0;
    m_mode   = nxt;
  endtask

  function automatic logic [7:0] exp_vec();
    logic [2:0] st;
    st = 3'(m_mode);
    return {st, m_mode == M_ACTIVE, m_mode == M_ACTIVE || m_mode == M_DRAIN,
            m_flush, m_mode == M_ERR, m_tout};
  endfunction

  task automatic step(input bit rst, input logic [1:0] req, input bit ovf, input int cnt);
    i_rst               = rst;
    i_state_request     = req;
    i_overflow_detected = ovf;
    i_buf_count         = CW'(cnt);
    @(posedge clk);
    model_step(rst, req, ovf, cnt);
    #1;
  endtask

  task automatic to_active();
    step(1, 2'd0, 0, 0);
    step(0, 2'd1, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 2'd1, 1, 9);
    step(1, 2'd1, 0, 9);
    checks++;
    if (dut_vec !== 8'b000_0_0_0_0_0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 8'b000_0_0_0_0_0);
    end
    // Overflow and non-ACTIVE requests are ignored in RESET; no flush on release.
    step(0, 2'd2, 1, 5);
    step(0, 2'd3, 1, 5);
    checks++;
    if (dut_vec !== 8'b000_0_0_0_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_hold got=%b exp=%b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_activate();
    step(0, 2'd1, 0, 0);
    checks++;
    if (dut_vec !== 8'b001_1_1_0_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL activate got=%b exp=%b", dut_vec, 8'b001_1_1_0_0_0);
    end
  endtask

  task automatic test_retrain_drain();
    to_active();
    step(0, 2'd2, 0, 5);
    checks++;
    if (dut_vec !== 8'b010_0_1_0_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL retrain_enter_drain got=%b exp=%b", dut_vec, 8'b010_0_1_0_0_0);
    end
    for (int c = 4; c >= 0; c--) begin
      step(0, 2'($urandom_range(3)), 0, c);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL retrain_drain_cnt%0d got=%b exp=%b", c, dut_vec, exp_vec());
      end
    end
    checks++;
    if (o_state_status !== 3'b011 || o_buf_flush !== 1'b0) begin
      errors++; $display("FAIL retrain_reached got=%b exp=011 flush=%b", o_state_status, o_buf_flush);
    end
    step(0, 2'd1, 0, 0);
    checks++;
    if (dut_vec !== 8'b001_1_1_0_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL retrain_to_active got=%b exp=%b", dut_vec, 8'b001_1_1_0_0_0);
    end
  endtask

  task automatic test_reset_empty();
    to_active();
    step(0, 2'd0, 0, 0);
    checks++;
    if (dut_vec !== 8'b010_0_1_0_0_0) begin
      errors++; $display("FAIL reset_empty_drain got=%b exp=%b", dut_vec, 8'b010_0_1_0_0_0);
    end
    step(0, 2'd1, 0, 0);
    checks++;
    if (dut_vec !== 8'b000_0_0_1_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_empty_flush got=%b exp=%b", dut_vec, 8'b000_0_0_1_0_0);
    end
    step(0, 2'd3, 0, 0);
    checks++;
    if (dut_vec !== 8'b000_0_0_0_0_0) begin
      errors++; $display("FAIL reset_empty_flush_once got=%b exp=%b", dut_vec, 8'b000_0_0_0_0_0);
    end
  endtask

  task automatic test_drain_timeout();
    to_active();
    step(0, 2'd2, 0, 3);
    for (int i = 0; i < DRAIN_TIMEOUT - 1; i++) begin
      step(0, 2'($urandom_range(3)), 0, 3);
      checks++;
      if (dut_vec !== 8'b010_0_1_0_0_0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL timeout_wait%0d got=%b exp=%b", i, dut_vec, 8'b010_0_1_0_0_0);
      end
    end
    step(0, 2'd1, 0, 3);
    checks++;
    if (dut_vec !== 8'b100_0_0_1_1_1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL timeout_fire got=%b exp=%b", dut_vec, 8'b100_0_0_1_1_1);
    end
    step(0, 2'd1, 0, 3);
    checks++;
    if (dut_vec !== 8'b100_0_0_0_1_0) begin
      errors++; $display("FAIL timeout_pulse_once got=%b exp=%b", dut_vec, 8'b100_0_0_0_1_0);
    end
  endtask

  task automatic test_overflow_priority();
    to_active();
    step(0, 2'd2, 1, 5);
    checks++;
    if (dut_vec !== 8'b100_0_0_1_1_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL ovf_wins got=%b exp=%b", dut_vec, 8'b100_0_0_1_1_0);
    end
    for (int r = 1; r <= 3; r++) begin
      step(0, 2'(r), 1'($urandom_range(1)), 4);
      checks++;
      if (dut_vec !== 8'b100_0_0_0_1_0) begin
        errors++; $display("FAIL ovf_sticky_req%0d got=%b exp=%b", r, dut_vec, 8'b100_0_0_0_1_0);
      end
    end
    step(0, 2'd0, 0, 4);
    checks++;
    if (dut_vec !== 8'b000_0_0_1_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL ovf_clear got=%b exp=%b", dut_vec, 8'b000_0_0_1_0_0);
    end
  endtask

  task automatic test_rst_mid_drain();
    to_active();
    step(0, 2'd2, 0, 7);
    step(0, 2'd1, 0, 6);
    step(0, 2'd0, 0, 6);
    step(1, 2'd2, 0, 6);
    checks++;
    if (dut_vec !== 8'b000_0_0_0_0_0) begin
      errors++; $display("FAIL rst_mid_drain got=%b exp=%b", dut_vec, 8'b000_0_0_0_0_0);
    end
    step(0, 2'd1, 0, 6);
    checks++;
    if (dut_vec !== 8'b001_1_1_0_0_0) begin
      errors++; $display("FAIL rst_mid_reactivate got=%b exp=%b", dut_vec, 8'b001_1_1_0_0_0);
    end
    step(0, 2'd0, 0, 0);
    step(0, 2'd3, 0, 0);
    checks++;
    if (dut_vec !== 8'b000_0_0_1_0_0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL rst_mid_fresh_target got=%b exp=%b", dut_vec, 8'b000_0_0_1_0_0);
    end
  endtask

  task automatic test_random();
    int zero_odds, ovf_odds, cnt;
    for (int ph = 0; ph < 2; ph++) begin
      zero_odds = (ph == 0) ? 4 : 80;
      ovf_odds  = (ph == 0) ? 32 : 300;
      for (int n = 0; n < 1500; n++) begin
        cnt = ($urandom_range(zero_odds - 1) == 0) ? 0 : int'($urandom_range(BUF_DEPTH, 1));
        step($urandom_range(249) == 0, 2'($urandom_range(3)),
             $urandom_range(ovf_odds - 1) == 0, cnt);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL random_ph%0d_n%0d got=%b exp=%b", ph, n, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_state_request = 2'd0; i_overflow_detected = 1'b0; i_buf_count = '0;
    test_reset();
    test_activate();
    test_retrain_drain();
    test_reset_empty();
    test_drain_timeout();
    test_overflow_priority();
    test_rst_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
